// File: rtl/meas_sequencer.sv
// meas_sequencer: round-robin arbiter sharing one DAC + charge ADC front-end
// among NCH search engines. Each grant loads the DAC, waits for it to settle,
// runs one measurement and returns the result to the granted channel.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | front-end free, arbitrate among pending requests
// S_LOAD   | dac_load strobe out, DAC latches the captured code
// S_SETTLE | counting DAC settle cycles
// S_MEAS   | meas_start strobe out, arm measurement timeout
// S_WAIT   | waiting for meas_done or timeout
// S_DONE   | q_valid (and timeout_err on abort) strobe to the owner
module meas_sequencer #(
  parameter int BUS_WIDTH = 10,
  parameter int NCH       = 4,
  parameter int SETTLE    = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req,
  input  logic [NCH*BUS_WIDTH-1:0] i_ref_req,
  input  logic                     meas_done,
  input  logic [BUS_WIDTH-1:0]     q_meas,
  output logic [BUS_WIDTH-1:0]     dac_code,
  output logic                     dac_load,
  output logic                     meas_start,
  output logic [NCH-1:0]           grant,
  output logic [BUS_WIDTH-1:0]     q_out,
  output logic [NCH-1:0]           q_valid,
  output logic                     timeout_err,
  output logic                     busy
);

  localparam int CH_W = $clog2(NCH);
  // Both timers are down-counters loaded with (length - 1) and end at zero.
  localparam int ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ST_W-1:0] ST_LD = ST_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [TO_W-1:0] TO_LD = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_MEAS, S_WAIT, S_DONE
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   ch;
  logic [ST_W-1:0]   st_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [CH_W-1:0]   pick;
  logic              found;

  // Round-robin pick: first pending request at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int i = 0; i < NCH; i++) begin
      if (!found && req[(int'(ptr) + i) % NCH]) begin
        found = 1'b1;
        pick  = CH_W'((int'(ptr) + i) % NCH);
      end
    end
  end

  // Sequencer FSM; every output is a register so nothing leaks combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      ch          <= '0;
      st_cnt      <= '0;
      to_cnt      <= '0;
      dac_code    <= '0;
      dac_load    <= 1'b0;
      meas_start  <= 1'b0;
      grant       <= '0;
      q_out       <= '0;
      q_valid     <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      dac_load    <= 1'b0;
      meas_start  <= 1'b0;
      q_valid     <= '0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            // i_ref_req is only looked at here; later changes are ignored.
            ch       <= pick;
            grant    <= NCH'(1) << pick;
            dac_code <= i_ref_req[pick*BUS_WIDTH +: BUS_WIDTH];
            dac_load <= 1'b1;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (SETTLE == 0) begin
            meas_start <= 1'b1;
            state      <= S_MEAS;
          end else begin
            st_cnt <= ST_LD;
            state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (st_cnt == '0) begin
            meas_start <= 1'b1;
            state      <= S_MEAS;
          end else begin
            st_cnt <= st_cnt - 1'b1;
          end
        end
        S_MEAS: begin
          to_cnt <= TO_LD;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the last allowed cycle still counts.
          if (meas_done) begin
            q_out   <= q_meas;
            q_valid <= grant;
            state   <= S_DONE;
          end else if (to_cnt == '0) begin
            q_out       <= '0;
            q_valid     <= grant;
            timeout_err <= 1'b1;
            state       <= S_DONE;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        S_DONE: begin
          grant <= '0;
          busy  <= 1'b0;
          ptr   <= CH_W'((int'(ch) + 1) % NCH);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_meas_sequencer.sv
// Directed bench for meas_sequencer: one default build (SETTLE=8, TIMEOUT=255)
// and one SETTLE=0 build sharing clock, reset and DAC codes.
module tb_meas_sequencer;
  localparam int BW = 10;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req0 = '0;
  logic [BW-1:0]   codes [N];
  logic [N*BW-1:0] i_ref_req;
  logic            meas_done = 1'b0;
  logic            meas_done0 = 1'b0;
  logic [BW-1:0]   q_meas = '0;
  logic [BW-1:0]   q_meas0 = '0;

  logic [BW-1:0] dac_code, q_out, dac_code0, q_out0;
  logic          dac_load, meas_start, timeout_err, busy;
  logic          dac_load0, meas_start0, timeout_err0, busy0;
  logic [N-1:0]  grant, q_valid, grant0, q_valid0;

  int npass  = 0;
  int ntotal = 0;

  assign i_ref_req = {codes[3], codes[2], codes[1], codes[0]};

  always #5 clk = ~clk;

  meas_sequencer #(.BUS_WIDTH(BW), .NCH(N), .SETTLE(8), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .req(req), .i_ref_req(i_ref_req),
    .meas_done(meas_done), .q_meas(q_meas), .dac_code(dac_code),
    .dac_load(dac_load), .meas_start(meas_start), .grant(grant),
    .q_out(q_out), .q_valid(q_valid), .timeout_err(timeout_err), .busy(busy)
  );

  meas_sequencer #(.BUS_WIDTH(BW), .NCH(N), .SETTLE(0), .TIMEOUT(255)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .i_ref_req(i_ref_req),
    .meas_done(meas_done0), .q_meas(q_meas0), .dac_code(dac_code0),
    .dac_load(dac_load0), .meas_start(meas_start0), .grant(grant0),
    .q_out(q_out0), .q_valid(q_valid0), .timeout_err(timeout_err0), .busy(busy0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Called in an IDLE cycle with req already applied; returns in the next IDLE cycle.
  task automatic txn(input int c, input logic [BW-1:0] qv, input int dly,
                     input logic [N-1:0] req_after);
    logic [N-1:0] oh;
    oh = 4'(1) << c;
    tick();
    chk("grant", 32'(grant), 32'(oh));
    chk("dac_load", 32'(dac_load), 1);
    chk("dac_code", 32'(dac_code), 32'(codes[c]));
    repeat (8) tick();
    chk("pre_start", 32'(meas_start), 0);
    tick();
    chk("meas_start", 32'(meas_start), 1);
    repeat (dly) tick();
    meas_done = 1'b1;
    q_meas    = qv;
    tick();
    meas_done = 1'b0;
    chk("q_valid", 32'(q_valid), 32'(oh));
    chk("q_out", 32'(q_out), 32'(qv));
    chk("timeout_err", 32'(timeout_err), 0);
    req = req_after;
    tick();
    chk("idle_grant", 32'(grant), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("q_valid_once", 32'(q_valid), 0);
  endtask

  initial begin
    codes[0] = 10'd100;
    codes[1] = 10'd200;
    codes[2] = 10'd826;
    codes[3] = 10'd400;

    // reset state
    #3;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_dac_code", 32'(dac_code), 0);
    chk("rst_dac_load", 32'(dac_load), 0);
    chk("rst_meas_start", 32'(meas_start), 0);
    chk("rst_q_out", 32'(q_out), 0);
    chk("rst_q_valid", 32'(q_valid), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_busy0", 32'(busy0), 0);
    tick();
    rst = 1'b1;

    // single request on channel 2
    req = 4'b0100;
    txn(2, 10'd300, 5, 4'b0000);

    // async reset during WAIT; pointer was 3, so channel 3 owns the front-end
    req = 4'b1111;
    tick();
    chk("t5_grant", 32'(grant), 32'(4'b1000));
    repeat (12) tick();
    chk("t5_busy_wait", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_grant_rst", 32'(grant), 0);
    chk("t5_busy_rst", 32'(busy), 0);
    chk("t5_dac_code_rst", 32'(dac_code), 0);
    chk("t5_q_out_rst", 32'(q_out), 0);
    repeat (2) begin
      tick();
      chk("t5_no_q_valid", 32'(q_valid), 0);
    end
    rst = 1'b1;

    // all four requesting: service from channel 0 in rotation
    for (int k = 0; k < 8; k++) begin
      txn(k % 4, 10'(50 + k * 37), 3, (k == 7) ? 4'b0000 : 4'b1111);
    end

    // measurement never completes on channel 1
    req = 4'b0010;
    tick();
    chk("t3_grant", 32'(grant), 32'(4'b0010));
    repeat (9) tick();
    chk("t3_meas_start", 32'(meas_start), 1);
    repeat (255) tick();
    chk("t3_still_wait", 32'(q_valid), 0);
    chk("t3_busy", 32'(busy), 1);
    tick();
    chk("t3_q_valid", 32'(q_valid), 32'(4'b0010));
    chk("t3_timeout_err", 32'(timeout_err), 1);
    chk("t3_q_out", 32'(q_out), 0);
    req = 4'b0000;
    tick();
    chk("t3_err_once", 32'(timeout_err), 0);
    chk("t3_idle_grant", 32'(grant), 0);
    req = 4'b1000;
    txn(3, 10'd640, 2, 4'b0000);

    // stray meas_done in IDLE and SETTLE; DAC code changes after capture
    meas_done = 1'b1;
    q_meas    = 10'd77;
    tick();
    meas_done = 1'b0;
    chk("t4_idle_busy", 32'(busy), 0);
    chk("t4_idle_q_valid", 32'(q_valid), 0);
    chk("t4_idle_q_out", 32'(q_out), 640);
    codes[0] = 10'd0;
    req = 4'b0001;
    tick();
    chk("t4_grant", 32'(grant), 1);
    chk("t4_dac_code", 32'(dac_code), 0);
    tick();
    meas_done = 1'b1;
    codes[0]  = 10'd1023;
    tick();
    meas_done = 1'b0;
    chk("t4_settle_start", 32'(meas_start), 0);
    chk("t4_settle_q_valid", 32'(q_valid), 0);
    chk("t4_settle_dac", 32'(dac_code), 0);
    repeat (6) tick();
    chk("t4_pre_start", 32'(meas_start), 0);
    tick();
    chk("t4_meas_start", 32'(meas_start), 1);
    repeat (2) tick();
    meas_done = 1'b1;
    q_meas    = 10'd123;
    tick();
    meas_done = 1'b0;
    chk("t4_q_valid", 32'(q_valid), 1);
    chk("t4_q_out", 32'(q_out), 123);
    chk("t4_dac_hold", 32'(dac_code), 0);
    req = 4'b0000;
    tick();
    chk("t4_idle", 32'(busy), 0);

    // SETTLE=0 build, back-to-back channels 0 and 1
    req0 = 4'b0011;
    tick();
    chk("t6_grant_a", 32'(grant0), 1);
    chk("t6_load_a", 32'(dac_load0), 1);
    chk("t6_code_a", 32'(dac_code0), 1023);
    tick();
    chk("t6_start_a", 32'(meas_start0), 1);
    chk("t6_load_off", 32'(dac_load0), 0);
    tick();
    meas_done0 = 1'b1;
    q_meas0    = 10'd555;
    tick();
    meas_done0 = 1'b0;
    chk("t6_q_valid_a", 32'(q_valid0), 1);
    chk("t6_q_out_a", 32'(q_out0), 555);
    tick();
    chk("t6_gap_grant", 32'(grant0), 0);
    chk("t6_gap_busy", 32'(busy0), 0);
    tick();
    chk("t6_grant_b", 32'(grant0), 2);
    chk("t6_load_b", 32'(dac_load0), 1);
    chk("t6_code_b", 32'(dac_code0), 200);
    req0 = 4'b0000;
    tick();
    chk("t6_start_b", 32'(meas_start0), 1);
    tick();
    meas_done0 = 1'b1;
    q_meas0    = 10'd9;
    tick();
    meas_done0 = 1'b0;
    chk("t6_q_valid_b", 32'(q_valid0), 2);
    chk("t6_q_out_b", 32'(q_out0), 9);
    tick();
    chk("t6_idle", 32'(busy0), 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
